cfo_seq: RTL and testbench

Top-level sequencer for the CFO estimation datapath. Per frame it runs two estimator passes through the existing go/done estimator controller: a coarse pass at short-preamble lag, then a fine pass at long-preamble lag. It latches both estimates and outputs their full-width sum as the frame CFO. A watchdog flags an estimator that never completes. It sits between the packet detector (start/abort) and the CFO compensation stage (cfo_out/cfo_valid).

---
 rtl/cfo_pkg.sv | 23 ++
 rtl/cfo_wdog.sv | 28 ++
 rtl/cfo_seq.sv | 123 ++++++++++++
 tb/tb_cfo_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cfo_pkg.sv
// cfo_pkg: shared types and default widths for the CFO estimation path.
// The sequencer, estimator and compensation blocks all import it.
package cfo_pkg;

  localparam int EST_W   = 16;    // signed estimator result width
  localparam int LAG_W   = 7;     // lag configuration bus width
  localparam int LAG_S   = 16;    // coarse pass lag (short preamble)
  localparam int LAG_L   = 64;    // fine pass lag (long preamble)
  localparam int TMO_W   = 12;    // watchdog counter width
  localparam int TMO_MAX = 4095;  // wait cycles allowed per pass

  typedef enum logic [2:0] {
    S_IDLE,
    S_C_GO,
    S_C_WAIT,
    S_F_GO,
    S_F_WAIT,
    S_SUM,
    S_DONE,
    S_TMO
  } cfo_state_t;

endpackage

// File: rtl/cfo_wdog.sv
// cfo_wdog: per-pass watchdog counter.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   clr    in  restart count at zero (issued on each GO state)
//   en     in  count one more wait cycle
//   term   out count has reached TMO_MAX-1 (last permitted wait cycle)
module cfo_wdog #(
  parameter int TMO_W   = 12,
  parameter int TMO_MAX = 4095
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) r_cnt <= '0;
    else if (en)      r_cnt <= r_cnt + 1'b1;
  end

  assign term = (r_cnt == TMO_W'(TMO_MAX - 1));

endmodule

// File: rtl/cfo_seq.sv
// cfo_seq: frame-level CFO sequencer. Runs a coarse estimator pass at the
// short-preamble lag, then a fine pass at the long-preamble lag, and reports
// the full-width sum of both estimates. A watchdog aborts a pass whose
// estimator never answers and raises a sticky error.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, abort    frame request pulse / frame cancel level
//   est_go, est_lag go pulse and lag configuration to the estimator
//   est_done,est_val estimator completion pulse and signed result
//   cfo_out,cfo_valid coarse+fine sum and its one-cycle strobe
//   busy, err       not-idle indicator, sticky timeout flag
module cfo_seq #(
  parameter int EST_W   = 16,
  parameter int LAG_W   = 7,
  parameter int LAG_S   = 16,
  parameter int LAG_L   = 64,
  parameter int TMO_W   = 12,
  parameter int TMO_MAX = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             est_go,
  output logic [LAG_W-1:0] est_lag,
  input  logic             est_done,
  input  logic [EST_W-1:0] est_val,
  output logic [EST_W:0]   cfo_out,
  output logic             cfo_valid,
  output logic             busy,
  output logic             err
);

  import cfo_pkg::*;

  cfo_state_t       r_state;
  logic [EST_W-1:0] r_coarse;
  logic [EST_W-1:0] r_fine;
  logic [EST_W:0]   r_cfo;
  logic             r_err;

  logic w_wait;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_term;

  assign w_wait   = (r_state == S_C_WAIT) || (r_state == S_F_WAIT);
  assign w_wd_clr = (r_state == S_C_GO) || (r_state == S_F_GO);
  // Stop counting once the pass resolves so the terminal check never wraps.
  assign w_wd_en  = w_wait && !est_done && !abort;

  cfo_wdog #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (w_wd_clr),
    .en    (w_wd_en),
    .term  (w_wd_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_coarse <= '0;
      r_fine   <= '0;
      r_cfo    <= '0;
      r_err    <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      // Abort beats est_done and timeout; results and err are left as-is.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_err   <= 1'b0;
            r_state <= S_C_GO;
          end
        end
        S_C_GO: r_state <= S_C_WAIT;
        S_C_WAIT: begin
          if (est_done) begin
            r_coarse <= est_val;
            r_state  <= S_F_GO;
          end else if (w_wd_term) begin
            r_state <= S_TMO;
          end
        end
        S_F_GO: r_state <= S_F_WAIT;
        S_F_WAIT: begin
          if (est_done) begin
            r_fine  <= est_val;
            r_state <= S_SUM;
          end else if (w_wd_term) begin
            r_state <= S_TMO;
          end
        end
        S_SUM: begin
          // One extra bit holds any sum of two EST_W-bit signed values.
          r_cfo   <= {r_coarse[EST_W-1], r_coarse} + {r_fine[EST_W-1], r_fine};
          r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        S_TMO: begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode straight from the state register.
  assign est_go    = (r_state == S_C_GO) || (r_state == S_F_GO);
  assign est_lag   = ((r_state == S_F_GO) || (r_state == S_F_WAIT)) ?
                     LAG_W'(LAG_L) : LAG_W'(LAG_S);
  assign cfo_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign cfo_out   = r_cfo;
  assign err       = r_err;

endmodule

// File: tb/tb_cfo_seq.sv
module tb_cfo_seq;

  logic        clk = 1'b0;
  logic        reset, start, abort, est_done;
  logic [15:0] est_val;
  logic        est_go, cfo_valid, busy, err;
  logic [6:0]  est_lag;
  logic [16:0] cfo_out;

  int total = 0;
  int bad   = 0;
  int go_cnt = 0;
  int vld_cnt = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  cfo_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .est_go(est_go), .est_lag(est_lag), .est_done(est_done), .est_val(est_val),
    .cfo_out(cfo_out), .cfo_valid(cfo_valid), .busy(busy), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every cfo_valid pops one expected sum.
  always @(negedge clk) begin
    if (!reset) begin
      if (est_go) go_cnt++;
      if (cfo_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid cfo_out=%0h t=%0t", cfo_out, $time);
        end else begin
          chk("sb_cfo_out", cfo_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame; coarse est_done arrives on wait cycle index cdly.
  task automatic run_frame(input logic [15:0] c, input logic [15:0] f,
                           input logic [16:0] exp, input int cdly, input logic extra);
    int g0;
    tick();
    start = 1'b1;
    g0 = go_cnt;
    exp_q.push_back(exp);
    tick();                       // C_GO
    start = 1'b0;
    chk("c_go", est_go, 1);
    chk("c_lag", est_lag, 16);
    chk("err_clr", err, 0);
    chk("busy_run", busy, 1);
    tick();                       // C_WAIT
    repeat (cdly) tick();
    chk("c_wait_lag", est_lag, 16);
    chk("c_wait_go", est_go, 0);
    est_done = 1'b1;
    est_val  = c;
    tick();                       // F_GO
    est_done = 1'b0;
    est_val  = 16'h5a5a;
    chk("f_go", est_go, 1);
    chk("f_lag", est_lag, 64);
    tick();                       // F_WAIT
    chk("f_wait_lag", est_lag, 64);
    est_done = 1'b1;
    est_val  = f;
    if (extra) start = 1'b1;
    tick();                       // SUM
    est_done = 1'b0;
    est_val  = 16'h5a5a;
    start    = 1'b0;
    tick();                       // DONE
    chk("done_valid", cfo_valid, 1);
    chk("done_cfo", cfo_out, exp);
    if (extra) start = 1'b1;
    tick();                       // IDLE
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", cfo_valid, 0);
    chk("go_pair", go_cnt - g0, 2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; est_done = 1'b0; est_val = 16'h5a5a;
    tick();
    tick();
    chk("rst_go", est_go, 0);
    chk("rst_lag", est_lag, 16);
    chk("rst_cfo", cfo_out, 0);
    chk("rst_valid", cfo_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // Nominal and extremes
    run_frame(16'd100, 16'hFFFD, 17'd97, 0, 1'b0);
    run_frame(16'h8000, 16'h8000, 17'h10000, 0, 1'b0);
    run_frame(16'h7FFF, 16'h7FFF, 17'h0FFFE, 0, 1'b0);

    // Timeout on the fine pass
    tick(); start = 1'b1;
    tick(); start = 1'b0;         // C_GO
    tick(); est_done = 1'b1; est_val = 16'd5;  // C_WAIT
    tick(); est_done = 1'b0;      // F_GO
    tick();                       // F_WAIT, first wait cycle
    repeat (4094) tick();
    chk("tmo_last_wait_lag", est_lag, 64);
    chk("tmo_last_wait_err", err, 0);
    tick();                       // TMO
    chk("tmo_state_busy", busy, 1);
    chk("tmo_state_err", err, 0);
    chk("tmo_state_lag", est_lag, 16);
    tick();                       // IDLE
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_cfo_keep", cfo_out, 17'h0FFFE);
    tick();
    chk("tmo_err_hold", err, 1);
    run_frame(16'd100, 16'hFFFD, 17'd97, 0, 1'b0);

    // Abort in C_WAIT, late est_done ignored
    tick(); start = 1'b1;
    tick(); start = 1'b0;         // C_GO
    tick(); abort = 1'b1;         // C_WAIT
    tick(); abort = 1'b0; est_done = 1'b1; est_val = 16'd50;
    chk("abort_busy", busy, 0);
    chk("abort_cfo", cfo_out, 17'd97);
    tick(); est_done = 1'b0;
    chk("abort_busy2", busy, 0);
    chk("abort_go", est_go, 0);

    // start and abort together in IDLE
    tick(); start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk("sa_idle_busy", busy, 0);
    chk("sa_idle_go", est_go, 0);

    // Stray starts in F_WAIT and DONE
    run_frame(16'd5, 16'd6, 17'd11, 0, 1'b1);
    tick();
    chk("stray_busy", busy, 0);

    // Coarse est_done on the watchdog terminal cycle
    run_frame(16'd10, 16'd20, 17'd30, 4094, 1'b0);

    // Reset in F_GO
    tick(); start = 1'b1;
    tick(); start = 1'b0;         // C_GO
    tick(); est_done = 1'b1; est_val = 16'd7;  // C_WAIT
    tick(); est_done = 1'b0;      // F_GO
    chk("pre_rst_go", est_go, 1);
    reset = 1'b1;
    tick();
    chk("mrst_go", est_go, 0);
    chk("mrst_lag", est_lag, 16);
    chk("mrst_cfo", cfo_out, 0);
    chk("mrst_valid", cfo_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err, 0);
    reset = 1'b0;
    run_frame(16'hFFFF, 16'd2, 17'd1, 0, 1'b0);

    repeat (4) tick();
    chk("sb_drain", exp_q.size(), 0);
    chk("valid_cnt", vld_cnt, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
